// File: rtl/ram_arbiter.sv
// ram_arbiter: post-reset fill of a shared single-port RAM, then round-robin
// sharing between two requesters, one full read or write per grant.
module ram_arbiter #(
    parameter int unsigned AW      = 10,
    parameter int unsigned DW      = 8,
    parameter bit          INIT_EN = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          init_busy,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_we,
    output logic          ram_sel,
    input  logic [DW-1:0] ram_dout
);

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StAccess,
        StCapture,
        StAck
    } state_e;

    localparam logic [AW-1:0] KMax = '1;

    state_e        state_q, state_d;
    logic [AW-1:0] k_q, k_d;
    logic          last_q, last_d;
    logic          gnt_idx_q, gnt_idx_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;

    // Fill pattern (2*k) mod 2^DW, computed in DW bits so the shift drops the carry.
    logic [DW-1:0] k_dw;
    logic [DW-1:0] fill_pat;
    assign k_dw     = DW'(k_q);
    assign fill_pat = k_dw << 1;

    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;

    // State register; last resets to 1 so the first contested grant goes to requester 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if (INIT_EN) begin
                state_q <= StInit;
            end else begin
                state_q <= StIdle;
            end
            k_q       <= '0;
            last_q    <= 1'b1;
            gnt_idx_q <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            last_q    <= last_d;
            gnt_idx_q <= gnt_idx_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    // Next-state, arbitration and RAM/handshake output decode.
    always_comb begin
        logic pick;
        pick      = 1'b0;
        state_d   = state_q;
        k_d       = k_q;
        last_d    = last_q;
        gnt_idx_d = gnt_idx_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        ack0      = 1'b0;
        ack1      = 1'b0;
        init_busy = 1'b0;
        ram_addr  = '0;
        ram_din   = '0;
        ram_we    = 1'b0;
        ram_sel   = 1'b0;

        case (state_q)
            StInit: begin
                init_busy = 1'b1;
                ram_sel   = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = k_q;
                ram_din   = fill_pat;
                k_d       = k_q + 1'b1;
                if (k_q == KMax) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (req0 || req1) begin
                    // Contested: pick whoever was not served last.
                    pick      = (req0 && req1) ? ~last_q : req1;
                    gnt_idx_d = pick;
                    last_d    = pick;
                    we_d      = pick ? we1 : we0;
                    addr_d    = pick ? addr1 : addr0;
                    wdata_d   = pick ? wdata1 : wdata0;
                    state_d   = StAccess;
                end
            end
            StAccess: begin
                gnt0     = ~gnt_idx_q;
                gnt1     = gnt_idx_q;
                ram_sel  = 1'b1;
                ram_we   = we_q;
                ram_addr = addr_q;
                ram_din  = wdata_q;
                state_d  = StCapture;
            end
            StCapture: begin
                gnt0 = ~gnt_idx_q;
                gnt1 = gnt_idx_q;
                // ram_dout is valid this cycle after the read strobe in ACCESS.
                if (!we_q) begin
                    if (gnt_idx_q) begin
                        rdata1_d = ram_dout;
                    end else begin
                        rdata0_d = ram_dout;
                    end
                end
                state_d = StAck;
            end
            StAck: begin
                gnt0    = ~gnt_idx_q;
                gnt1    = gnt_idx_q;
                ack0    = ~gnt_idx_q;
                ack1    = gnt_idx_q;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Sequencing controller for the shared single-port 1024x8 `ram` block. After reset it fills the RAM with the pattern `(2*k) % 256`. It then shares the RAM between two requesters with a round-robin arbiter, running one complete read or write transaction per grant over a req/ack handshake. It sits directly in front of the `ram` instance and is the only driver of the RAM's address, data and strobe inputs.

## Interface
Parameters:
- `AW`, 10, address width (RAM depth is 2^AW).
- `DW`, 8, data width.
- `INIT_EN`, 1, when 1 run the post-reset fill; when 0 go straight to IDLE.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req0`, `req1`  in  1  transaction request; held high until the matching ack.
- `we0`, `we1`  in  1  1 = write, 0 = read; stable while req is high.
- `addr0`, `addr1`  in  AW  transaction address; stable while req is high.
- `wdata0`, `wdata1`  in  DW  write data; stable while req is high.
- `gnt0`, `gnt1`  out  1  requester owns the RAM (ACCESS through ACK).
- `ack0`, `ack1`  out  1  one-cycle completion pulse.
- `rdata0`, `rdata1`  out  DW  registered read data; valid from the ack cycle until the next read by that requester.
- `init_busy`  out  1  high while the fill runs.
- `ram_addr`  out  AW  to RAM address.
- `ram_din`  out  DW  to RAM data_in.
- `ram_we`  out  1  to RAM write.
- `ram_sel`  out  1  to RAM select.
- `ram_dout`  in  DW  from RAM data_out.

## Operation
- RAM contract:
  - A write takes effect at the rising edge that ends a cycle with `ram_sel=1` and `ram_we=1`.
  - A read strobe is a cycle with `ram_sel=1` and `ram_we=0`. `ram_dout` is valid throughout the following cycle.
- States: INIT, IDLE, ACCESS, CAPTURE, ACK.
- INIT:
  - Counter k runs 0..2^AW-1. Each cycle drives `ram_sel=1`, `ram_we=1`, `ram_addr=k`, `ram_din=(2*k) mod 2^DW`.
  - After k = 2^AW-1 go to IDLE. Fill takes exactly 2^AW cycles.
  - `init_busy=1` in INIT only.
  - Requests raised during INIT stay pending; they are not granted or acked.
- IDLE:
  - RAM outputs are all 0.
  - Only req0 high: grant 0. Only req1 high: grant 1.
  - Both high: grant the requester other than `last` (round-robin pointer).
  - On any grant, latch that requester's we/addr/wdata, set `last` to the granted index, and go to ACCESS.
- ACCESS: drive `ram_sel=1`, `ram_we`=latched we, `ram_addr`/`ram_din` from the latched values. Go to CAPTURE.
- CAPTURE:
  - RAM outputs are 0.
  - If the transaction is a read, load `ram_dout` into the granted requester's rdata at the end of the cycle. The other requester's rdata is unchanged.
  - Go to ACK.
- ACK: pulse the granted ack for one cycle, then go to IDLE.
- Grants: `gntN` is high in ACCESS, CAPTURE and ACK for the granted N; both gnts are low otherwise.
- Requester rule: deassert req in the cycle after ack. A req still high in IDLE is treated as a new request.
- `last` resets to 1, so the first contested grant goes to requester 0.
- Writes use the full DW bits of wdata. Address width is exactly AW; no wrap or range check is needed.

## Timing
- Reset (async, immediate): state=INIT (IDLE if INIT_EN=0), k=0, `last`=1.
- Output values while in reset:
  - `init_busy` = INIT_EN.
  - `ram_sel`/`ram_we` = INIT_EN; `ram_addr` = 0; `ram_din` = 0 (the INIT drive for k=0).
  - gnt, ack and rdata all 0.
- First fill write occurs at the first clock edge after `rst_n` rises. `init_busy` falls after edge 2^AW.
- Transaction latency: req sampled high in IDLE at edge t.
  - gnt high from t through t+3.
  - RAM strobe during cycle t..t+1.
  - ack high in cycle t+2..t+3 (req to ack = 3 edges).
  - Back in IDLE at edge t+3.
- Minimum spacing is 4 cycles per transaction. A continuously contested pair alternates grants 0,1,0,1.
- Reset asserted mid-transaction:
  - Transaction is aborted; no ack is issued.
  - A write already strobed may have landed.
  - Fill restarts from k=0.

## Test plan
- Reset then run INIT_EN=1: `init_busy` high for exactly 1024 cycles. RAM addr 5 reads 10, addr 200 reads 144, addr 1023 reads 254.
- Requester 0 writes 0xA5 to 0x3FF, then reads 0x3FF: each ack arrives 3 edges after req. `rdata0`=0xA5; `rdata1` unchanged at 0.
- req0 and req1 raised simultaneously after init, each re-requesting immediately after its ack for 6 transactions: grant order 0,1,0,1,0,1. Never both gnt high.
- req1 raised during INIT (read of addr 7): no gnt until `init_busy` falls. Then `rdata1`=14 with ack1 3 edges after the first IDLE sample.
- `rst_n` pulsed low in the ACCESS cycle of a read by requester 0: ack0 never pulses. `init_busy` rises immediately; fill restarts at addr 0.
- INIT_EN=0: `init_busy` stays 0. A req0 read at the first post-reset edge is granted immediately, ack0 follows 3 edges later.
